// File: rtl/prio_enc_pkg.sv
// Shared types and helpers for the priority request encoder.
package prio_enc_pkg;

    // Output stage: EMPTY has nothing to offer, HOLD presents out_idx.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } enc_state_e;

    // Index width for n request lines; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational picker: searches cand downward from start, wrapping 0 -> N-1,
// and returns the first set index.
module prio_pick
    import prio_enc_pkg::*;
#(
    parameter  int unsigned N  = 8,
    localparam int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  cand,
    input  logic [IW-1:0] start,
    output logic [IW-1:0] idx,
    output logic          found
);

    // Descending circular scan; the first hit wins.
    always_comb begin
        int unsigned pos;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = ((int'(start) % N) + N - k) % N;
            if (!found && cand[pos]) begin
                found = 1'b1;
                idx   = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/prio_req_encoder.sv
// Priority request encoder with a one-entry output stage, a pending set and
// a saturating drop counter. Define PRIO_ENC_RR_EN for round-robin selection;
// otherwise selection is fixed priority (highest index wins).
module prio_req_encoder
    import prio_enc_pkg::*;
#(
    parameter  int unsigned N     = 8,
    parameter  int unsigned CNT_W = 8,
    localparam int unsigned IW    = idx_width(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IW-1:0]    out_idx,
    output logic [N-1:0]     pend,
    output logic [CNT_W-1:0] drop_cnt
);

    enc_state_e       state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [N-1:0]     pend_q, pend_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic [N-1:0]     cand;
    logic             load;
    logic [IW-1:0]    start;
    logic [IW-1:0]    pick_idx;
    logic             pick_found;
    logic             grant;
    logic [N-1:0]     grant_mask;
    logic             drop_hit;

`ifdef PRIO_ENC_RR_EN
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    assign start = rr_ptr_q;
`else
    assign start = IW'(N - 1);
`endif

    prio_pick #(
        .N (N)
    ) u_pick (
        .cand  (cand),
        .start (start),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Candidate set, load slot and grant decode.
    always_comb begin
        cand       = pend_q | req;
        load       = (state_q == ST_EMPTY) || out_ready;
        grant      = load && pick_found;
        grant_mask = grant ? ({{(N-1){1'b0}}, 1'b1} << pick_idx) : '0;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a load slot refills or empties the stage, else it holds.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = pick_found ? ST_HOLD : ST_EMPTY;
        end
    end

    // FSM outputs.
    always_comb begin
        out_valid = (state_q == ST_HOLD);
    end

    // Datapath next state: index, pending set, drop counter.
    always_comb begin
        idx_d = grant ? pick_idx : idx_q;
        // A req on the granted line is absorbed by the grant itself.
        pend_d = load ? (cand & ~grant_mask) : (pend_q | req);
        // A request landing on an already-pending, ungranted line is merged.
        drop_hit = |(req & pend_q & ~grant_mask);
        drop_d = (drop_hit && (drop_q != '1)) ? drop_q + CNT_W'(1) : drop_q;
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            pend_q <= '0;
            drop_q <= '0;
        end else begin
            idx_q  <= idx_d;
            pend_q <= pend_d;
            drop_q <= drop_d;
        end
    end

`ifdef PRIO_ENC_RR_EN
    // Round-robin pointer: next search starts just below the last grant.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant) begin
            rr_ptr_d = (pick_idx == '0) ? IW'(N - 1) : pick_idx - IW'(1);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= IW'(N - 1);
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    assign out_idx  = idx_q;
    assign pend     = pend_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_prio_req_encoder.sv
// Self-checking bench for prio_req_encoder, with a scoreboard fed by a
// reference model. A second instance with CNT_W=2 checks saturation.
module tb_prio_req_encoder;

`ifdef PRIO_ENC_RR_EN
    localparam bit RrMode = 1'b1;
`else
    localparam bit RrMode = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic       out_ready = 1'b0;

    logic       out_valid;
    logic [2:0] out_idx;
    logic [7:0] pend;
    logic [7:0] drop_cnt;

    logic       s_out_valid;
    logic [2:0] s_out_idx;
    logic [7:0] s_pend;
    logic [1:0] s_drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    prio_req_encoder #(
        .N     (8),
        .CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .pend      (pend),
        .drop_cnt  (drop_cnt)
    );

    prio_req_encoder #(
        .N     (8),
        .CNT_W (2)
    ) dut_small (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_valid (s_out_valid),
        .out_ready (out_ready),
        .out_idx   (s_out_idx),
        .pend      (s_pend),
        .drop_cnt  (s_drop_cnt)
    );

    typedef struct {
        logic        valid;
        logic [2:0]  idx;
        logic [7:0]  pend;
        int unsigned drop;
        int unsigned drop_s;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state
    logic        m_valid;
    logic [2:0]  m_idx;
    logic [7:0]  m_pend;
    int unsigned m_drop;
    int unsigned m_drop_s;
    int          m_rr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int pick_ref(input logic [7:0] c, input int start);
        for (int k = 0; k < 8; k++) begin
            int p;
            p = start - k;
            if (p < 0) p = p + 8;
            if (c[p]) return p;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid  = 1'b0;
        m_idx    = 3'd0;
        m_pend   = 8'h00;
        m_drop   = 0;
        m_drop_s = 0;
        m_rr     = 7;
        sb_q.delete();
    endtask

    // Drive one cycle, predict the result, then compare after the edge.
    task automatic step(input string tag, input logic [7:0] r, input logic rdy);
        logic [7:0] cand;
        logic [7:0] gmask;
        logic [7:0] old_pend;
        int         g;
        exp_t       e;
        req       = r;
        out_ready = rdy;
        old_pend  = m_pend;
        cand      = m_pend | r;
        gmask     = 8'h00;
        if (!m_valid || rdy) begin
            g = pick_ref(cand, RrMode ? m_rr : 7);
            if (g >= 0) begin
                gmask   = 8'h01 << g;
                m_valid = 1'b1;
                m_idx   = 3'(g);
                m_rr    = (g == 0) ? 7 : g - 1;
            end else begin
                m_valid = 1'b0;
            end
            m_pend = cand & ~gmask;
        end else begin
            m_pend = m_pend | r;
        end
        if ((r & old_pend & ~gmask) != 8'h00) begin
            if (m_drop < 255) m_drop++;
            if (m_drop_s < 3) m_drop_s++;
        end
        e.valid  = m_valid;
        e.idx    = m_idx;
        e.pend   = m_pend;
        e.drop   = m_drop;
        e.drop_s = m_drop_s;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_eq({tag, ".valid"}, 32'(out_valid), 32'(e.valid));
        check_eq({tag, ".idx"}, 32'(out_idx), 32'(e.idx));
        check_eq({tag, ".pend"}, 32'(pend), 32'(e.pend));
        check_eq({tag, ".drop"}, 32'(drop_cnt), e.drop);
        check_eq({tag, ".drop_small"}, 32'(s_drop_cnt), e.drop_s);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, ".valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, ".idx"}, 32'(out_idx), 32'd0);
        check_eq({tag, ".pend"}, 32'(pend), 32'h00);
        check_eq({tag, ".drop"}, 32'(drop_cnt), 32'd0);
        check_eq({tag, ".drop_small"}, 32'(s_drop_cnt), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        req       = 8'h00;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        check_zero(tag);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();

        // Reset state
        do_reset("rst0");

        // Single pulse drains in priority order 5, 3, 2
        step("p2c0", 8'h2C, 1'b1);
        check_eq("seq.v0", 32'(out_valid), 32'd1);
        check_eq("seq.i0", 32'(out_idx), 32'd5);
        step("p2c1", 8'h00, 1'b1);
        check_eq("seq.i1", 32'(out_idx), 32'd3);
        step("p2c2", 8'h00, 1'b1);
        check_eq("seq.i2", 32'(out_idx), 32'd2);
        step("p2c3", 8'h00, 1'b1);
        check_eq("seq.v3", 32'(out_valid), 32'd0);

        // Stall: held grant, pending line, merged request
        step("st0", 8'h81, 1'b0);
        check_eq("stall.idx", 32'(out_idx), 32'd7);
        check_eq("stall.pend", 32'(pend), 32'h01);
        step("st1", 8'h00, 1'b0);
        step("st2", 8'h01, 1'b0);
        check_eq("drop.one", 32'(drop_cnt), 32'd1);
        check_eq("drop.pend", 32'(pend), 32'h01);
        for (int i = 0; i < 4; i++) step("st3", 8'h01, 1'b0);
        check_eq("drop.five", 32'(drop_cnt), 32'd5);
        check_eq("drop.sat", 32'(s_drop_cnt), 32'd3);

        // Held 0x81 with consumer always ready
        do_reset("rst1");
        for (int i = 0; i < 6; i++) begin
            step("hold81", 8'h81, 1'b1);
            check_eq("b2b.valid", 32'(out_valid), 32'd1);
            check_eq("b2b.idx", 32'(out_idx), (RrMode && (i % 2 == 1)) ? 32'd0 : 32'd7);
        end
        step("drain", 8'h00, 1'b1);
        step("drain", 8'h00, 1'b1);

        // Asynchronous reset between edges while holding with pend=0x0C
        do_reset("rst2");
        step("pre", 8'h1C, 1'b0);
        check_eq("pre.valid", 32'(out_valid), 32'd1);
        check_eq("pre.pend", 32'(pend), 32'h0C);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async");
        model_reset();
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("post", 8'h00, 1'b1);
            check_eq("post.valid", 32'(out_valid), 32'd0);
        end

        // Random traffic against the model
        for (int i = 0; i < 80; i++) begin
            step("rnd", 8'($urandom) & 8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/prio_req_encoder.md
PRIO_REQ_ENCODER -- requirements
Module: prio_req_encoder

Interface
REQ-001 SHALL have parameter N, default 8, meaning the number of request lines (N >= 2); IW = $clog2(N) is derived, not overridable.
REQ-002 SHALL have parameter CNT_W, default 8, meaning the width of the drop counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port req, input, N bits: request pulses or levels, bit i = line i.
REQ-006 SHALL have port out_valid, output, 1 bit: out_idx holds a granted index.
REQ-007 SHALL have port out_ready, input, 1 bit: consumer accepts out_idx this cycle.
REQ-008 SHALL have port out_idx, output, IW bits: the granted request index.
REQ-009 SHALL have port pend, output, N bits: the registered pending set, excluding the bit held in the output stage.
REQ-010 SHALL have port drop_cnt, output, CNT_W bits: saturating count of merged (lost) requests.

Function
REQ-011 SHALL compute cand = pend | req each cycle.
REQ-012 SHALL treat the output stage as a 2-state FSM: EMPTY (out_valid=0) and HOLD (out_valid=1); a load slot exists when in EMPTY, or when in HOLD with out_ready=1.
REQ-013 On a load slot with cand != 0, SHALL register the selected index into out_idx, enter HOLD, and clear that bit from pend. Latency is 1 cycle from req to out_valid.
REQ-014 On a load slot with cand == 0, SHALL enter or remain in EMPTY; out_idx SHALL keep its previous value.
REQ-015 In HOLD with out_ready=0, SHALL hold out_idx and out_valid stable and set pend |= req.
REQ-016 The default selection SHALL be fixed priority: the highest set index of cand wins (index N-1 highest).
REQ-017 A req bit coinciding with its own grant in the same cycle SHALL be absorbed: it is not re-pended and not counted as a drop.
REQ-018 SHALL increment drop_cnt by 1 in any cycle where some i has req[i]=1 and pend[i]=1 and i is not granted that cycle; the increment is at most 1 per cycle; the counter saturates at 2^CNT_W-1 and does not wrap.
REQ-019 Back-to-back grants SHALL be supported: with out_ready held at 1 and a non-empty cand, out_valid SHALL stay 1 every cycle.

Reset
REQ-020 While rst_n=0, SHALL immediately force out_valid=0, out_idx=0, pend=0, drop_cnt=0, FSM=EMPTY, and (if compiled in) rr_ptr=N-1.
REQ-021 Reset asserted mid-operation SHALL discard the held grant and all pending requests; there is no replay after release.
REQ-022 The first load slot SHALL occur on the first rising edge after rst_n deasserts.

Configuration
REQ-023 Macro PRIO_ENC_RR_EN SHALL select round-robin mode when defined; when undefined, the block is fixed-priority only and contains no rr_ptr logic.
REQ-024 With PRIO_ENC_RR_EN defined, the search SHALL start at rr_ptr and descend, wrapping from 0 to N-1; the first set bit of cand wins.
REQ-025 With PRIO_ENC_RR_EN defined, after a grant of index g the block SHALL set rr_ptr = g-1, or rr_ptr = N-1 when g = 0; rr_ptr SHALL be unchanged when nothing is granted.
REQ-026 With rr_ptr = N-1 (the reset value), round-robin selection SHALL equal fixed priority.

Structure
REQ-027 Package prio_enc_pkg SHALL hold the FSM state enum (ST_EMPTY, ST_HOLD) and the function clog2-based index-width helper.
REQ-028 Selection SHALL reside in sub-module prio_pick (combinational; inputs cand and start pointer; outputs idx and found); fixed mode ties the start pointer to N-1.

Verification
REQ-029 Bench SHALL check: reset -> out_valid=0, out_idx=0, pend=8'h00, drop_cnt=0.
REQ-030 Bench SHALL check: N=8, req=8'b0010_1100 for one cycle, out_ready=1 -> out_idx = 5, 3, 2 on 3 consecutive valid cycles, then out_valid=0.
REQ-031 Bench SHALL check: out_ready=0, req=8'h81 pulse -> out_idx=7 held and pend=8'h01; then req=8'h01 pulse -> drop_cnt=1 and pend stays 8'h01.
REQ-032 Bench SHALL check: req=8'h81 held, out_ready=1 -> fixed mode gives 7,7,7,...; with PRIO_ENC_RR_EN the sequence is 7,0,7,0,...
REQ-033 Bench SHALL check: CNT_W=2 with 5 drop cycles -> drop_cnt saturates at 3.
REQ-034 Bench SHALL check: rst_n pulsed low between clock edges while out_valid=1 and pend=8'h0C -> all outputs are 0 immediately; after release with req=0, out_valid stays 0.
